bitmap_offset_transform: RTL and testbench

- Per-pixel offset remapper between an object's square/rect logic and its bitmap ROM lookup.
- Mirrors the pixel offset about X, Y or both, statically or animated on a frame-counted toggle.
- Mode changes requested mid-frame are deferred to the next frame boundary so a sprite never tears.
- Output is one registered pipeline stage; the drawing request is delayed alongside the offsets.

---
 rtl/bitmap_offset_transform_pkg.sv | 37 +++
 rtl/bitmap_offset_transform_if.sv | 27 ++
 rtl/bitmap_offset_transform_frame_flip_timer.sv | 48 ++++
 rtl/bitmap_offset_transform.sv | 107 ++++++++++
 tb/tb_bitmap_offset_transform.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bitmap_offset_transform_pkg.sv
// Shared types and helpers for bitmap offset transforms.
package bitmap_xform_pkg;

  typedef enum logic [2:0] {
    MODE_NONE      = 3'd0,
    MODE_MIRROR_X  = 3'd1,
    MODE_MIRROR_Y  = 3'd2,
    MODE_MIRROR_XY = 3'd3,
    MODE_AUTO_X    = 3'd4,
    MODE_AUTO_Y    = 3'd5,
    MODE_AUTO_XY   = 3'd6,
    MODE_RSVD      = 3'd7
  } xform_mode_t;

  // Effective mirror flags {mx, my}; animated modes mirror only in phase 1,
  // the reserved code behaves like NONE.
  function automatic logic [1:0] mirror_flags(input xform_mode_t mode, input logic phase);
    logic [1:0] flags;
    flags = 2'b00;
    case (mode)
      MODE_MIRROR_X:  flags = 2'b10;
      MODE_MIRROR_Y:  flags = 2'b01;
      MODE_MIRROR_XY: flags = 2'b11;
      MODE_AUTO_X:    flags = {phase, 1'b0};
      MODE_AUTO_Y:    flags = {1'b0, phase};
      MODE_AUTO_XY:   flags = {phase, phase};
      default:        flags = 2'b00;
    endcase
    return flags;
  endfunction

  // True for the frame-animated modes, which run the flip timer.
  function automatic logic is_auto(input xform_mode_t mode);
    return (mode == MODE_AUTO_X) || (mode == MODE_AUTO_Y) || (mode == MODE_AUTO_XY);
  endfunction

endpackage

// File: rtl/bitmap_offset_transform_if.sv
// Pixel/offset bus between object rect logic, the transform and the bitmap ROM.
interface bitmap_offset_transform_if #(
  parameter int COORD_W = 11
) ();
  logic               startOfFrame;
  logic [COORD_W-1:0] offsetX;
  logic [COORD_W-1:0] offsetY;
  logic               drawingRequest;
  logic [2:0]         modeIn;
  logic               modeLoad;
  logic               pause;
  logic [COORD_W-1:0] newOffsetX;
  logic [COORD_W-1:0] newOffsetY;
  logic               drawingRequestOut;
  logic [2:0]         activeMode;
  logic               flipPhase;

  modport master (
    output startOfFrame, offsetX, offsetY, drawingRequest, modeIn, modeLoad, pause,
    input  newOffsetX, newOffsetY, drawingRequestOut, activeMode, flipPhase
  );

  modport slave (
    input  startOfFrame, offsetX, offsetY, drawingRequest, modeIn, modeLoad, pause,
    output newOffsetX, newOffsetY, drawingRequestOut, activeMode, flipPhase
  );
endinterface

// File: rtl/bitmap_offset_transform_frame_flip_timer.sv
// Frame-counted toggle: flips phase once every FLIP_PERIOD+1 counted frames.
module frame_flip_timer #(
  parameter int FLIP_PERIOD = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic pause,
  input  logic reload,   // restart the animation: timer to period, phase to 0
  input  logic autoEn,   // count only while an animated mode is active
  output logic flipPhase
);
  localparam int TW = (FLIP_PERIOD < 1) ? 1 : $clog2(FLIP_PERIOD + 1);
  localparam logic [TW-1:0] RELOAD_V = TW'(FLIP_PERIOD);

  logic [TW-1:0] timer_q, timer_d;
  logic          phase_q, phase_d;

  // Next-state: reload wins, otherwise count down on unpaused animated frames.
  always_comb begin
    timer_d = timer_q;
    phase_d = phase_q;
    if (reload) begin
      timer_d = RELOAD_V;
      phase_d = 1'b0;
    end else if (startOfFrame && !pause && autoEn) begin
      if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end else begin
        timer_d = RELOAD_V;
        phase_d = ~phase_q;
      end
    end
  end

  // Timer/phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= RELOAD_V;
      phase_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      phase_q <= phase_d;
    end
  end

  assign flipPhase = phase_q;
endmodule

// File: rtl/bitmap_offset_transform.sv
// Mirrors object pixel offsets about X/Y, statically or animated, with
// frame-boundary mode switching and one registered output stage.
module bitmap_offset_transform
  import bitmap_xform_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int COORD_W         = 11,
  parameter int FLIP_PERIOD     = 5
) (
  input logic                        clk,
  input logic                        reset,
  bitmap_offset_transform_if.slave   bus
);
  localparam logic [COORD_W-1:0] WIDTH_C   = COORD_W'(OBJECT_WIDTH_X);
  localparam logic [COORD_W-1:0] HEIGHT_C  = COORD_W'(OBJECT_HEIGHT_Y);
  localparam logic [COORD_W-1:0] WIDTH_M1  = COORD_W'(OBJECT_WIDTH_X - 1);
  localparam logic [COORD_W-1:0] HEIGHT_M1 = COORD_W'(OBJECT_HEIGHT_Y - 1);

  xform_mode_t active_q, active_d;
  xform_mode_t pend_q, pend_d;
  logic        pvalid_q, pvalid_d;
  logic        apply;
  xform_mode_t load_mode;
  logic        flip_phase;
  logic [1:0]  flags;
  logic        in_x, in_y;

  logic [COORD_W-1:0] newx_q, newx_d;
  logic [COORD_W-1:0] newy_q, newy_d;
  logic               dr_q, dr_d;

  assign load_mode = xform_mode_t'(bus.modeIn);
  // A same-cycle load counts as pending so it can be applied immediately.
  assign apply     = bus.startOfFrame && (pvalid_q || bus.modeLoad);

  // Mode bookkeeping: loads stay pending until the next frame boundary.
  always_comb begin
    active_d = active_q;
    pend_d   = pend_q;
    pvalid_d = pvalid_q;
    if (bus.modeLoad) begin
      pend_d = load_mode;
    end
    if (apply) begin
      active_d = bus.modeLoad ? load_mode : pend_q;
      pvalid_d = 1'b0;
    end else if (bus.modeLoad) begin
      pvalid_d = 1'b1;
    end
  end

  // Mode registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= MODE_NONE;
      pend_q   <= MODE_NONE;
      pvalid_q <= 1'b0;
    end else begin
      active_q <= active_d;
      pend_q   <= pend_d;
      pvalid_q <= pvalid_d;
    end
  end

  frame_flip_timer #(
    .FLIP_PERIOD (FLIP_PERIOD)
  ) u_flip_timer (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (bus.startOfFrame),
    .pause        (bus.pause),
    .reload       (apply),
    .autoEn       (is_auto(active_q)),
    .flipPhase    (flip_phase)
  );

  // Mirror decision uses the mode/phase in effect before this edge, so a
  // newly applied mode shows up on pixels one cycle after startOfFrame.
  always_comb begin
    flags  = mirror_flags(active_q, flip_phase);
    in_x   = bus.offsetX < WIDTH_C;
    in_y   = bus.offsetY < HEIGHT_C;
    newx_d = (flags[1] && in_x) ? (WIDTH_M1 - bus.offsetX) : bus.offsetX;
    newy_d = (flags[0] && in_y) ? (HEIGHT_M1 - bus.offsetY) : bus.offsetY;
    dr_d   = bus.drawingRequest && in_x && in_y;
  end

  // Output pipeline stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      newx_q <= '0;
      newy_q <= '0;
      dr_q   <= 1'b0;
    end else begin
      newx_q <= newx_d;
      newy_q <= newy_d;
      dr_q   <= dr_d;
    end
  end

  assign bus.newOffsetX        = newx_q;
  assign bus.newOffsetY        = newy_q;
  assign bus.drawingRequestOut = dr_q;
  assign bus.activeMode        = active_q;
  assign bus.flipPhase         = flip_phase;
endmodule

// File: tb/tb_bitmap_offset_transform.sv
// Randomized + directed bench for bitmap_offset_transform with a frame-count model.
module tb_bitmap_offset_transform;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int CW = 11;
  localparam int P  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitmap_offset_transform_if #(.COORD_W(CW)) bus ();

  bitmap_offset_transform #(
    .OBJECT_WIDTH_X  (W),
    .OBJECT_HEIGHT_Y (H),
    .COORD_W         (CW),
    .FLIP_PERIOD     (P)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d @%0t", nm, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase is derived from how many animated, unpaused frames have elapsed
  // since the last mode apply: it flips every P+1 of them.
  int          m_active, m_pend, m_k;
  bit          m_pvalid;
  logic [CW-1:0] exp_x, exp_y;
  logic        exp_dr;

  function automatic int phase_of(input int k);
    return (k / (P + 1)) % 2;
  endfunction
  function automatic bit mx_of(input int mode, input int ph);
    return (mode == 1) || (mode == 3) || (((mode == 4) || (mode == 6)) && ph == 1);
  endfunction
  function automatic bit my_of(input int mode, input int ph);
    return (mode == 2) || (mode == 3) || (((mode == 5) || (mode == 6)) && ph == 1);
  endfunction
  function automatic logic [CW-1:0] remap(input int off, input int size, input bit m);
    if (m && off < size) return CW'(size - 1 - off);
    return CW'(off);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_pend <= 0; m_pvalid <= 0; m_k <= 0;
      exp_x <= '0; exp_y <= '0; exp_dr <= 1'b0;
    end else begin
      exp_x  <= remap(int'(bus.offsetX), W, mx_of(m_active, phase_of(m_k)));
      exp_y  <= remap(int'(bus.offsetY), H, my_of(m_active, phase_of(m_k)));
      exp_dr <= bus.drawingRequest && (int'(bus.offsetX) < W) && (int'(bus.offsetY) < H);
      if (bus.modeLoad) m_pend <= int'(bus.modeIn);
      if (bus.startOfFrame && (m_pvalid || bus.modeLoad)) begin
        m_active <= bus.modeLoad ? int'(bus.modeIn) : m_pend;
        m_pvalid <= 0;
        m_k      <= 0;
      end else begin
        if (bus.modeLoad) m_pvalid <= 1;
        if (bus.startOfFrame && !bus.pause && m_active >= 4 && m_active <= 6) m_k <= m_k + 1;
      end
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("cmp_newX",   int'(bus.newOffsetX),        int'(exp_x));
      chk("cmp_newY",   int'(bus.newOffsetY),        int'(exp_y));
      chk("cmp_drOut",  int'(bus.drawingRequestOut), int'(exp_dr));
      chk("cmp_mode",   int'(bus.activeMode),        m_active);
      chk("cmp_phase",  int'(bus.flipPhase),         phase_of(m_k));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit sof, input int ox, input int oy, input bit dr,
                      input int mi, input bit ml, input bit pz);
    bus.startOfFrame   = sof;
    bus.offsetX        = CW'(ox);
    bus.offsetY        = CW'(oy);
    bus.drawingRequest = dr;
    bus.modeIn         = 3'(mi);
    bus.modeLoad       = ml;
    bus.pause          = pz;
    @(negedge clk);
  endtask

  initial begin
    int counted;
    int ph;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("reset_newX", int'(bus.newOffsetX), 0);
    chk("reset_dr",   int'(bus.drawingRequestOut), 0);
    chk("reset_mode", int'(bus.activeMode), 0);
    chk("reset_phase", int'(bus.flipPhase), 0);
    rst = 1'b0;
    chk_en = 1;

    // NONE passthrough
    step(0, 3, 7, 1, 0, 0, 0);
    chk("none_x", int'(bus.newOffsetX), 3);
    chk("none_y", int'(bus.newOffsetY), 7);
    chk("none_dr", int'(bus.drawingRequestOut), 1);

    // MIRROR_XY deferred to frame start
    step(0, 0, 0, 1, 3, 1, 0);
    chk("defer_mode", int'(bus.activeMode), 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("defer_mode2", int'(bus.activeMode), 0);
    step(1, 0, 31, 1, 0, 0, 0);
    chk("xy_applied", int'(bus.activeMode), 3);
    chk("xy_sof_pixel_unmirrored", int'(bus.newOffsetX), 0);
    step(0, 0, 31, 1, 0, 0, 0);
    chk("xy_a_x", int'(bus.newOffsetX), 31);
    chk("xy_a_y", int'(bus.newOffsetY), 0);
    step(0, 5, 10, 1, 0, 0, 0);
    chk("xy_b_x", int'(bus.newOffsetX), 26);
    chk("xy_b_y", int'(bus.newOffsetY), 21);

    // Same-cycle load + SOF, MIRROR_Y
    step(1, 4, 4, 1, 2, 1, 0);
    chk("same_cycle_mode", int'(bus.activeMode), 2);
    step(0, 4, 4, 1, 0, 0, 0);
    chk("my_x", int'(bus.newOffsetX), 4);
    chk("my_y", int'(bus.newOffsetY), 27);

    // Out of bounds under MIRROR_X
    step(1, 0, 0, 0, 1, 1, 0);
    step(0, 40, 2, 1, 0, 0, 0);
    chk("oob_x", int'(bus.newOffsetX), 40);
    chk("oob_dr", int'(bus.drawingRequestOut), 0);
    chk("oob_y", int'(bus.newOffsetY), 2);

    // AUTO_X toggling
    step(1, 0, 0, 0, 4, 1, 0);
    chk("autox_mode", int'(bus.activeMode), 4);
    for (int i = 1; i <= 14; i++) begin
      step(1, 0, 0, 1, 0, 0, 0);
      ph = (i / 6) % 2;
      chk("autox_phase", int'(bus.flipPhase), ph);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("autox_x", int'(bus.newOffsetX), ph ? 31 : 0);
    end

    // Pause for 3 frames delays the toggle by 3
    step(1, 0, 0, 0, 4, 1, 0);
    counted = 0;
    for (int i = 1; i <= 12; i++) begin
      bit pz;
      pz = (i >= 4 && i <= 6);
      step(1, 0, 0, 0, 0, 0, pz);
      if (!pz) counted++;
      chk("pause_phase", int'(bus.flipPhase), (counted / 6) % 2);
      if (i == 8) chk("pause_phase_i8", int'(bus.flipPhase), 0);
      if (i == 9) chk("pause_phase_i9", int'(bus.flipPhase), 1);
    end

    // Async reset during AUTO_XY with phase 1
    step(1, 0, 0, 0, 6, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 1, 0, 0, 0);
    chk("axy_phase", int'(bus.flipPhase), 1);
    chk("axy_x", int'(bus.newOffsetX), 30);
    chk("axy_y", int'(bus.newOffsetY), 29);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", int'(bus.newOffsetX), 0);
    chk("arst_y", int'(bus.newOffsetY), 0);
    chk("arst_dr", int'(bus.drawingRequestOut), 0);
    chk("arst_mode", int'(bus.activeMode), 0);
    chk("arst_phase", int'(bus.flipPhase), 0);
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) == 0), $urandom_range(0, 47), $urandom_range(0, 47),
           $urandom_range(0, 1), $urandom_range(0, 7), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0));
    end

    step(0, 0, 0, 0, 0, 0, 0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
